// File: rtl/sram_arb_pkg.sv
// Shared types and limits for the two-requester SRAM arbiter.
// Holds the controller state encoding, read-latency bounds and default widths.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // WAIT counter preload: counts down to zero across RD_LAT cycles.
  function automatic logic [1:0] lat_load(input int lat);
    int l;
    l = (lat < RD_LAT_MIN) ? RD_LAT_MIN : ((lat > RD_LAT_MAX) ? RD_LAT_MAX : lat);
    return 2'(l - 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker. Index 0 is fetch, index 1 is data.
// The last-grant register only advances when the caller accepts a grant.
module arb_rr2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  logic r_last_data;
  logic w_pick_data;

  // On a tie, favour whichever side did not win last time.
  assign w_pick_data = i_req[1] & (~i_req[0] | ~r_last_data);
  assign o_gnt       = {w_pick_data, i_req[0] & ~w_pick_data};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_data <= 1'b0;
    end else if (i_take && (|i_req)) begin
      r_last_data <= w_pick_data;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM shared between an instruction fetch port and a load/store port.
// One transaction in flight: IDLE -> ISSUE -> (WAIT x RD_LAT) -> DONE -> IDLE.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,
  output logic                inst_busy,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_valid,
  output logic                data_busy,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [1:0] LAT_LOAD = lat_load(RD_LAT);

  arb_state_e        r_state, w_next;
  logic              r_gnt_data;
  logic              r_we;
  logic [1:0]        r_cnt;
  logic              r_sram_en;
  logic [BE_W-1:0]   r_sram_we;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  logic [1:0]        w_gnt;
  logic              w_idle;
  logic              w_grant;
  logic              w_capture;
  logic              w_done;

  assign w_idle = (r_state == ST_IDLE);

  arb_rr2 u_rr (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  ({data_req, inst_req}),
    .i_take (w_idle),
    .o_gnt  (w_gnt)
  );

  assign w_grant   = w_idle && (|w_gnt);
  assign w_capture = (r_state == ST_WAIT) && (r_cnt == 2'd0);
  assign w_done    = (r_state == ST_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (|w_gnt) w_next = ST_ISSUE;
      ST_ISSUE: w_next = r_we ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (r_cnt == 2'd0) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // The SRAM-side registers are loaded at grant so they are live during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt_data   <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= 2'd0;
      r_sram_en    <= 1'b0;
      r_sram_we    <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_state   <= w_next;
      r_sram_en <= w_grant;
      r_sram_we <= (w_grant && w_gnt[1] && data_we) ? data_be : '0;
      if (w_grant) begin
        r_gnt_data   <= w_gnt[1];
        r_we         <= w_gnt[1] & data_we;
        r_sram_addr  <= w_gnt[1] ? data_addr : inst_addr;
        r_sram_wdata <= w_gnt[1] ? data_wdata : '0;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= LAT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_capture) begin
        if (r_gnt_data) r_data_rdata <= sram_rdata;
        else            r_inst_rdata <= sram_rdata;
      end
    end
  end

  assign inst_valid = w_done & ~r_gnt_data;
  assign data_valid = w_done &  r_gnt_data;
  assign inst_busy  = inst_req & ~inst_valid;
  assign data_busy  = data_req & ~data_valid;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;
  assign sram_en    = r_sram_en;
  assign sram_we    = r_sram_we;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-timing model.
module tb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int RD_LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_valid, inst_busy;
  logic          data_req, data_we;
  logic [BW-1:0] data_be;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          data_valid, data_busy;
  logic          sram_en;
  logic [BW-1:0] sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_valid(inst_valid), .inst_busy(inst_busy),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_valid(data_valid), .data_busy(data_busy),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: a grant in an idle cycle T fixes every later output by offset from T.
  bit            m_known = 0;
  bit            m_act = 0;
  bit            m_data, m_store, m_last_data;
  longint        cyc = 0;
  longint        m_start;
  int            m_done_rel;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_irdata, m_drdata;
  int            rel;
  bit            e_iv, e_dv, e_en;
  logic [BW-1:0] e_we;
  int            starve_i = 0, starve_d = 0;

  always @(negedge clk) begin
    if (m_known) begin
      e_iv = 0; e_dv = 0; e_en = 0; e_we = '0;
      if (m_act) begin
        rel  = int'(cyc - m_start);
        e_en = (rel == 1);
        if (rel == 1 && m_store) e_we = m_be;
        if (rel == m_done_rel) begin e_iv = !m_data; e_dv = m_data; end
      end
      chk("sram_en", sram_en, e_en);
      chk("sram_we", sram_we, e_we);
      if (e_en) chk("sram_addr", sram_addr, m_addr);
      if (e_en && m_store) chk("sram_wdata", sram_wdata, m_wdata);
      chk("inst_valid", inst_valid, e_iv);
      chk("data_valid", data_valid, e_dv);
      chk("inst_busy", inst_busy, inst_req & ~e_iv);
      chk("data_busy", data_busy, data_req & ~e_dv);
      chk("inst_rdata", inst_rdata, m_irdata);
      chk("data_rdata", data_rdata, m_drdata);
      starve_i = inst_busy ? starve_i + 1 : 0;
      starve_d = data_busy ? starve_d + 1 : 0;
      if (starve_i > 40 || starve_d > 40) begin
        n_fail++;
        $display("FAIL busy_bound: inst %0d data %0d cycles, required <= 40", starve_i, starve_d);
        starve_i = 0; starve_d = 0;
      end
    end
    if (rst) begin
      m_known = 1; m_act = 0; m_last_data = 0; m_irdata = '0; m_drdata = '0;
    end else if (m_known) begin
      if (m_act) begin
        rel = int'(cyc - m_start);
        if (!m_store && rel == 1 + RD_LAT) begin
          if (m_data) m_drdata = sram_rdata;
          else        m_irdata = sram_rdata;
        end
        if (rel == m_done_rel) m_act = 0;
      end else if (inst_req || data_req) begin
        m_data      = data_req && (!inst_req || !m_last_data);
        m_last_data = m_data;
        m_act       = 1;
        m_start     = cyc;
        m_store     = m_data && data_we;
        m_be        = data_be;
        m_addr      = m_data ? data_addr : inst_addr;
        m_wdata     = data_wdata;
        m_done_rel  = m_store ? 2 : 2 + RD_LAT;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  bit pv_i, pv_d;

  initial begin
    rst = 1; inst_req = 0; inst_addr = '0; data_req = 0; data_we = 0;
    data_be = '0; data_addr = '0; data_wdata = '0; sram_rdata = '0;
    repeat (3) step();
    rst = 0;
    neg();
    chk("rst_en", sram_en, 0); chk("rst_we", sram_we, 0); chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0); chk("rst_ivalid", inst_valid, 0);
    chk("rst_irdata", inst_rdata, 0); chk("rst_drdata", data_rdata, 0);

    // Fetch
    step(); inst_req = 1; inst_addr = 32'hBFC00000; sram_rdata = 32'h24080001;
    neg(); chk("t1_busy", inst_busy, 1);
    step(); neg(); chk("t1_en", sram_en, 1); chk("t1_addr", sram_addr, 32'hBFC00000); chk("t1_we", sram_we, 0);
    step(); neg(); chk("t1_wait_en", sram_en, 0); chk("t1_wait_v", inst_valid, 0);
    step(); neg(); chk("t1_valid", inst_valid, 1); chk("t1_rdata", inst_rdata, 32'h24080001); chk("t1_busy_done", inst_busy, 0);
    step(); inst_req = 0;
    neg(); chk("t1_after_v", inst_valid, 0);

    // Store
    step(); data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h80000010; data_wdata = 32'h0000BEEF;
    step(); neg(); chk("t2_en", sram_en, 1); chk("t2_we", sram_we, 4'b0011);
    chk("t2_addr", sram_addr, 32'h80000010); chk("t2_wdata", sram_wdata, 32'h0000BEEF);
    step(); neg(); chk("t2_valid", data_valid, 1); chk("t2_rdata_kept", data_rdata, 0);
    step(); data_req = 0; data_we = 0;

    // Tie after reset: data, then inst, then data again
    step(); rst = 1;
    step(); rst = 0; inst_req = 1; inst_addr = 32'h00001000;
    data_req = 1; data_we = 0; data_addr = 32'h00002000; sram_rdata = 32'h11111111;
    neg(); chk("t3_ibusy0", inst_busy, 1);
    step(); neg(); chk("t3_g1_addr", sram_addr, 32'h00002000); chk("t3_g1_en", sram_en, 1);
    step(); neg(); chk("t3_ibusy2", inst_busy, 1);
    step(); neg(); chk("t3_dvalid", data_valid, 1); chk("t3_drdata", data_rdata, 32'h11111111);
    chk("t3_ibusy3", inst_busy, 1); chk("t3_no_iv", inst_valid, 0);
    step(); neg(); chk("t3_idle_en", sram_en, 0);
    step(); sram_rdata = 32'h22222222;
    neg(); chk("t3_g2_addr", sram_addr, 32'h00001000); chk("t3_g2_en", sram_en, 1);
    step(); step(); neg(); chk("t3_ivalid", inst_valid, 1); chk("t3_irdata", inst_rdata, 32'h22222222);
    step(); step(); neg(); chk("t3_g3_addr", sram_addr, 32'h00002000); chk("t3_g3_en", sram_en, 1);
    step(); inst_req = 0; data_req = 0;
    step(); neg(); chk("t3_dropped_after_grant", data_valid, 1);
    step();

    // Reset during WAIT of a fetch
    step(); inst_req = 1; inst_addr = 32'h0000ABC0; sram_rdata = 32'h33333333;
    step();
    step(); rst = 1;
    step(); rst = 0; sram_rdata = 32'h44444444;
    neg(); chk("t4_no_valid", inst_valid, 0); chk("t4_en", sram_en, 0); chk("t4_rdata", inst_rdata, 0);
    step(); neg(); chk("t4_reissue", sram_en, 1); chk("t4_v1", inst_valid, 0);
    step(); neg(); chk("t4_v2", inst_valid, 0);
    step(); neg(); chk("t4_valid", inst_valid, 1); chk("t4_rdata2", inst_rdata, 32'h44444444);
    step(); inst_req = 0;

    // Fetch pulse that never reaches IDLE
    step(); data_req = 1; data_we = 0; data_addr = 32'h00003000;
    step(); inst_req = 1; inst_addr = 32'h00005000;
    step(); inst_req = 0;
    step(); neg(); chk("t5_dvalid", data_valid, 1); chk("t5_iv", inst_valid, 0);
    step(); data_req = 0; neg(); chk("t5_en1", sram_en, 0); chk("t5_iv1", inst_valid, 0);
    step(); neg(); chk("t5_en2", sram_en, 0); chk("t5_iv2", inst_valid, 0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      neg(); pv_i = inst_valid; pv_d = data_valid;
      step();
      sram_rdata = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      if (inst_req && (pv_i || $urandom_range(0, 29) == 0)) inst_req = 0;
      else if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1; inst_addr = $urandom;
      end
      if (data_req && (pv_d || $urandom_range(0, 29) == 0)) data_req = 0;
      else if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1; data_we = 1'($urandom_range(0, 1)); data_be = 4'($urandom_range(0, 15));
        data_addr = $urandom; data_wdata = $urandom;
      end
    end
    step(); rst = 0; inst_req = 0; data_req = 0;
    repeat (8) step();
    neg();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
